// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array feeder and result collector:
// default geometry, collector state encoding and the matrix packing helper.
package sa_pkg;

  localparam int unsigned SaW = 16;
  localparam int unsigned SaN = 3;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StHold
  } sa_state_e;

  // Bit offset of C[r][c] in a row-major, MSB-first packed n x n matrix.
  function automatic int unsigned c_idx(input int unsigned r, input int unsigned c,
                                        input int unsigned n, input int unsigned w);
    return w * (n * n - 1 - (r * n + c));
  endfunction

endpackage

// File: rtl/sa_lane_deskew.sv
// One result lane: row counter, per-row write enable, completion flag and
// overflow detection for beats arriving after the lane is already full.
module sa_lane_deskew #(
  parameter int unsigned N = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_vld,
  output logic [N-1:0] o_wr_en,
  output logic         o_done,
  output logic         o_ovf
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] Full = CW'(N);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    o_wr_en = '0;
    o_ovf   = 1'b0;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && i_vld) begin
      if (cnt_q == Full) begin
        o_ovf = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        for (int unsigned k = 0; k < N; k++) begin
          if (cnt_q == CW'(k)) o_wr_en[k] = 1'b1;
        end
      end
    end
  end

  // Looks at the next count so the top can enter HOLD on the last write edge.
  assign o_done = (cnt_d == Full);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sa_result_collector.sv
// Deskews N systolic result lanes into a packed N x N matrix and presents it
// to the consumer with a valid/ready handshake.
module sa_result_collector
  import sa_pkg::*;
#(
  parameter int unsigned W = SaW,
  parameter int unsigned N = SaN
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [N-1:0]     i_lane_vld,
  input  logic [W*N-1:0]   i_lane_data,
  output logic [W*N*N-1:0] o_C,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_err
);

  sa_state_e state_q, state_d;
  logic [W*N*N-1:0] c_q, c_d;
  logic err_q, err_d;
  logic start_taken, lane_en;
  logic [N-1:0] done, ovf;
  logic [N-1:0] wr_en [N];

  always_comb begin
    start_taken = 1'b0;
    unique case (state_q)
      StIdle:    start_taken = i_start;
      StCollect: start_taken = i_start;
      StHold:    start_taken = i_start && i_ready;
      default:   start_taken = 1'b0;
    endcase
  end

  // A restart cycle discards its lane data.
  assign lane_en = (state_q == StCollect) && !i_start;

  for (genvar j = 0; j < N; j++) begin : g_lane
    sa_lane_deskew #(
      .N(N)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (start_taken),
      .i_en    (lane_en),
      .i_vld   (i_lane_vld[j]),
      .o_wr_en (wr_en[j]),
      .o_done  (done[j]),
      .o_ovf   (ovf[j])
    );
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) state_d = StCollect;
        if (|i_lane_vld) err_d = 1'b1;
      end
      StCollect: begin
        if (!i_start) begin
          if (&done) state_d = StHold;
          if (|ovf) err_d = 1'b1;
        end
      end
      StHold: begin
        if (i_ready) state_d = i_start ? StCollect : StIdle;
        if (|i_lane_vld) err_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    for (int unsigned j = 0; j < N; j++) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (wr_en[j][k]) c_d[c_idx(k, j, N, W) +: W] = i_lane_data[W*j +: W];
      end
    end
    if (start_taken) begin
      c_d   = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      c_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      err_q   <= err_d;
    end
  end

  assign o_C     = c_q;
  assign o_valid = (state_q == StHold);
  assign o_busy  = (state_q == StCollect);
  assign o_err   = err_q;

endmodule

// File: tb/tb_sa_result_collector.sv
// Self-checking bench for sa_result_collector: table of matrix streams with a
// scoreboard of expected matrices, plus reset and back-to-back sequences.
module tb_sa_result_collector;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 3;
  localparam int unsigned MW = W * N * N;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   lane_vld;
  logic [W*N-1:0] lane_data;
  logic [MW-1:0]  c_out;
  logic           valid, ready, busy, err;

  int checks = 0;
  int failures = 0;
  logic [MW-1:0] exp_q[$];

  typedef struct {
    logic [15:0] base;
    logic [15:0] sr;
    logic [15:0] sc;
    bit          skew;
    bit          extra;
    bit          poke;
    int          hold;
    bit          exp_err;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  sa_result_collector #(
    .W(W),
    .N(N)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_lane_vld  (lane_vld),
    .i_lane_data (lane_data),
    .o_C         (c_out),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_busy      (busy),
    .o_err       (err)
  );

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] build(input logic [15:0] base, input logic [15:0] sr,
                                          input logic [15:0] sc);
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[W*(N*N-1-(r*N+c)) +: W] = base + 16'(r) * sr + 16'(c) * sc;
    return m;
  endfunction

  task automatic run_stream(input bit do_start, input logic [15:0] base, input logic [15:0] sr,
                            input logic [15:0] sc, input bit skew, input bit extra);
    logic [MW-1:0] m;
    int last;
    m = build(base, sr, sc);
    exp_q.push_back(m);
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
      chk("busy_after_start", MW'(busy), MW'(1));
      chk("err_cleared_by_start", MW'(err), MW'(0));
    end
    last = skew ? 2 * N - 2 : N - 1;
    for (int t = 0; t <= last; t++) begin
      lane_vld  = '0;
      lane_data = '0;
      for (int j = 0; j < N; j++) begin
        int k;
        k = skew ? t - j : t;
        if (k >= 0 && k < N) begin
          lane_vld[j] = 1'b1;
          lane_data[W*j +: W] = base + 16'(k) * sr + 16'(j) * sc;
        end
      end
      if (extra && t == N) begin
        lane_vld[0] = 1'b1;
        lane_data[W-1:0] = 16'hdead;
      end
      step();
      if (t < last) begin
        chk("valid_low_while_collecting", MW'(valid), MW'(0));
      end else begin
        chk("valid_after_last_write", MW'(valid), MW'(1));
        chk("busy_drops_at_hold", MW'(busy), MW'(0));
      end
      if (extra && t == N) begin
        chk("overflow_sets_err", MW'(err), MW'(1));
        chk("overflow_row0_intact", MW'(c_out[MW-1 -: W*N]), MW'(m[MW-1 -: W*N]));
      end
    end
    lane_vld  = '0;
    lane_data = '0;
  endtask

  task automatic collect(input int hold, input bit start_w_ready, input bit poke,
                         input bit exp_err);
    logic [MW-1:0] m;
    int n;
    for (int i = 0; i < 20 && !valid; i++) step();
    if (!valid) begin
      chk("valid_timeout", MW'(valid), MW'(1));
      return;
    end
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", MW'(0), MW'(1));
      return;
    end
    m = exp_q.pop_front();
    n = 0;
    for (int i = 0; i <= hold; i++) begin
      chk("hold_matrix", c_out, m);
      if (valid) n++;
      ready = (i == hold);
      start = (i == 0 && hold > 0) || (i == hold && start_w_ready);
      if (poke && i == 0) begin
        lane_vld  = '1;
        lane_data = '1;
      end
      step();
      ready     = 1'b0;
      start     = 1'b0;
      lane_vld  = '0;
      lane_data = '0;
    end
    chk("valid_cycles", MW'(n), MW'(hold + 1));
    chk("valid_falls_after_ready", MW'(valid), MW'(0));
    if (start_w_ready) begin
      chk("busy_after_handshake_start", MW'(busy), MW'(1));
      chk("matrix_cleared_on_start", c_out, MW'(0));
      chk("err_after_handshake_start", MW'(err), MW'(0));
    end else begin
      chk("busy_low_in_idle", MW'(busy), MW'(0));
      chk("matrix_held_in_idle", c_out, m);
      chk("err_after_handshake", MW'(err), MW'(exp_err));
    end
  endtask

  initial begin
    vecs[0] = '{base: 16'h0000, sr: 16'h0100, sc: 16'h0001, skew: 1'b1, extra: 1'b0,
                poke: 1'b0, hold: 0, exp_err: 1'b0};
    vecs[1] = '{base: 16'h0000, sr: 16'h0100, sc: 16'h0001, skew: 1'b1, extra: 1'b0,
                poke: 1'b0, hold: 4, exp_err: 1'b0};
    vecs[2] = '{base: 16'h0f0f, sr: 16'h0000, sc: 16'h0000, skew: 1'b0, extra: 1'b0,
                poke: 1'b0, hold: 0, exp_err: 1'b0};
    vecs[3] = '{base: 16'h4000, sr: 16'h0111, sc: 16'h0022, skew: 1'b1, extra: 1'b1,
                poke: 1'b0, hold: 1, exp_err: 1'b1};
    vecs[4] = '{base: 16'ha000, sr: 16'h0010, sc: 16'h0003, skew: 1'b1, extra: 1'b0,
                poke: 1'b1, hold: 2, exp_err: 1'b1};

    rst_n = 1'b0; start = 1'b0; ready = 1'b0; lane_vld = '0; lane_data = '0;
    step();
    step();
    chk("reset_c", c_out, MW'(0));
    chk("reset_valid", MW'(valid), MW'(0));
    chk("reset_busy", MW'(busy), MW'(0));
    chk("reset_err", MW'(err), MW'(0));
    rst_n = 1'b1;

    lane_vld = 3'b010;
    lane_data = '1;
    step();
    lane_vld = '0;
    lane_data = '0;
    chk("idle_lane_sets_err", MW'(err), MW'(1));
    chk("idle_lane_data_discarded", c_out, MW'(0));

    for (int v = 0; v < 5; v++) begin
      run_stream(1'b1, vecs[v].base, vecs[v].sr, vecs[v].sc, vecs[v].skew, vecs[v].extra);
      collect(vecs[v].hold, 1'b0, vecs[v].poke, vecs[v].exp_err);
    end

    // Reset mid-collection, with start and lane data asserted during reset.
    start = 1'b1;
    step();
    start = 1'b0;
    lane_vld = '1;
    lane_data = {3{16'h5555}};
    step();
    step();
    rst_n = 1'b0;
    start = 1'b1;
    step();
    chk("midreset_c", c_out, MW'(0));
    chk("midreset_valid", MW'(valid), MW'(0));
    chk("midreset_busy", MW'(busy), MW'(0));
    chk("midreset_err", MW'(err), MW'(0));
    step();
    rst_n = 1'b1;
    start = 1'b0;
    lane_vld = '0;
    lane_data = '0;
    run_stream(1'b1, 16'h1000, 16'h0100, 16'h0010, 1'b1, 1'b0);
    collect(0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start with the handshake, next lane data on the following edge.
    run_stream(1'b1, 16'h2000, 16'h0001, 16'h0010, 1'b1, 1'b0);
    collect(1, 1'b1, 1'b0, 1'b0);
    run_stream(1'b0, 16'h3000, 16'h0200, 16'h0005, 1'b0, 1'b0);
    collect(0, 1'b0, 1'b0, 1'b0);

    chk("scoreboard_drained", MW'(exp_q.size()), MW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
